reg_wr_arbiter: RTL and testbench

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

---
 rtl/reg_wr_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/reg_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_reg_wr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wr_arb_pkg.sv
// Shared types for the register-write arbiter: controller states and the
// response encoding reported on resp_err.
package reg_wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    RESP_OK      = 1'b0,
    RESP_TIMEOUT = 1'b1
  } resp_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the requester after last_grant (modulo N_REQ) has the
// highest priority; the grant is one-hot, or all-zero when nothing requests.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant
);

  int idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates N_REQ register-write requesters onto one shared write port, with
// a wait-aware timeout and a one-cycle completion response per write.
module reg_wr_arbiter
  import reg_wr_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ*STRB_WIDTH-1:0] req_strb,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic                        resp_err,
  output logic [ADDR_WIDTH-1:0]       reg_wr_addr,
  output logic [DATA_WIDTH-1:0]       reg_wr_data,
  output logic [STRB_WIDTH-1:0]       reg_wr_strb,
  output logic                        reg_wr_en,
  input  logic                        reg_wr_wait,
  input  logic                        reg_wr_ack
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
  resp_e                 err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;

  logic [N_REQ-1:0]      grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;
  logic                  accept;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_strb  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // Outputs are masked during reset so an aborted write never pulses a response.
  assign accept      = !rst && (state_q == ST_IDLE) && (|req_valid);
  assign req_ready   = {N_REQ{accept}} & grant;
  assign reg_wr_en   = !rst && (state_q == ST_WRITE);
  assign resp_err    = !rst && (state_q == ST_RESP) && (err_q == RESP_TIMEOUT);
  assign reg_wr_addr = addr_q;
  assign reg_wr_data = data_q;
  assign reg_wr_strb = strb_q;

  always_comb begin
    resp_valid = '0;
    if (!rst && (state_q == ST_RESP)) resp_valid[gnt_idx_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_idx_d = gnt_idx_q;
    err_d     = err_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d    = sel_addr;
          data_d    = sel_data;
          strb_d    = sel_strb;
          gnt_idx_d = grant_idx;
          last_d    = grant_idx;
          cnt_d     = CNT_W'(TIMEOUT - 1);
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Ack takes precedence over an expiring counter; wait freezes the count.
        if (reg_wr_ack) begin
          err_d   = RESP_OK;
          state_d = ST_RESP;
        end else if (!reg_wr_wait) begin
          if (cnt_q == '0) begin
            err_d   = RESP_TIMEOUT;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      gnt_idx_q <= '0;
      err_q     <= RESP_OK;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_idx_q <= gnt_idx_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed vector table for the named scenarios,
// then randomized traffic checked against a transaction-level reference model.
module tb_reg_wr_arbiter;

  localparam int N  = 2;
  localparam int AW = 40;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*SW-1:0] req_strb;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic            resp_err;
  logic [AW-1:0]   reg_wr_addr;
  logic [DW-1:0]   reg_wr_data;
  logic [SW-1:0]   reg_wr_strb;
  logic            reg_wr_en;
  logic            reg_wr_wait;
  logic            reg_wr_ack;

  always #5 clk = ~clk;

  reg_wr_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_strb    (req_strb),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_wait (reg_wr_wait),
    .reg_wr_ack  (reg_wr_ack)
  );

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic       ack;
    logic       wt;
    logic [1:0] rdy;
    logic       en;
    logic [1:0] rv;
    logic       err;
    int         who;   // 0/1: that requester's fields, 2: zeros, 3: unchecked
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   passes = 0;

  task automatic add(input logic r, input logic [1:0] vld, input logic ack,
                     input logic wt, input logic [1:0] rdy, input logic en,
                     input logic [1:0] rv, input logic err, input int who);
    vec_t v;
    v.rst = r; v.vld = vld; v.ack = ack; v.wt = wt;
    v.rdy = rdy; v.en = en; v.rv = rv; v.err = err; v.who = who;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input logic [1:0] e_rdy, input logic e_en,
                         input logic [1:0] e_rv, input logic e_err, input bit chk_d,
                         input logic [AW-1:0] e_a, input logic [DW-1:0] e_d,
                         input logic [SW-1:0] e_s);
    bit ok;
    checks++;
    ok = (req_ready === e_rdy) && (reg_wr_en === e_en) &&
         (resp_valid === e_rv) && (resp_err === e_err);
    if (chk_d)
      ok = ok && (reg_wr_addr === e_a) && (reg_wr_data === e_d) && (reg_wr_strb === e_s);
    if (ok) passes++;
    else
      $display("FAIL %s: got ready=%b en=%b resp_valid=%b err=%b addr=%h data=%h strb=%h; want ready=%b en=%b resp_valid=%b err=%b addr=%h data=%h strb=%h (data checked=%0d)",
               name, req_ready, reg_wr_en, resp_valid, resp_err, reg_wr_addr, reg_wr_data,
               reg_wr_strb, e_rdy, e_en, e_rv, e_err, e_a, e_d, e_s, chk_d);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Reference model state: phase 0 idle, 1 writing, 2 responding.
  int            m_phase, m_last, m_gi, m_used, m_pick;
  bit            m_err, m_known;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_strb;

  initial begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [1:0]    e_rdy, e_rv;
    logic          e_en, e_err;

    rst = 1'b1; req_valid = '0; reg_wr_wait = 1'b0; reg_wr_ack = 1'b0;
    req_addr = {40'h00_0000_0020, 40'h00_0000_0010};
    req_data = {32'h1234_5678, 32'hDEAD_BEEF};
    req_strb = {4'h3, 4'hF};

    // reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 2);
    // single write, ack in the first write cycle
    add(0, 1, 0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // fairness: both requesting, order 0,1,0,1
    for (int r = 0; r < 4; r++) begin
      int g;
      g = r % 2;
      add(0, 3, 0, 0, 2'(1 << g), 0, 0, 0, (r == 0) ? 2 : 1 - g);
      add(0, 3, 1, 0, 0, 1, 0, 0, g);
      add(0, 3, 0, 0, 0, 0, 2'(1 << g), 0, g);
    end
    // timeout after four non-wait cycles
    add(0, 1, 0, 0, 1, 0, 0, 0, 1);
    for (int r = 0; r < 4; r++) add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ack in the same cycle the counter reaches zero
    add(0, 2, 0, 0, 2, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // reset in the second write cycle of requester 0; requester 0 wins again
    add(0, 1, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // wait held ten cycles, then ack
    add(0, 2, 0, 0, 2, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) add(0, 0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; req_valid = tbl[i].vld;
      reg_wr_ack = tbl[i].ack; reg_wr_wait = tbl[i].wt;
      @(negedge clk);
      case (tbl[i].who)
        0:       begin ea = 40'h10; ed = 32'hDEAD_BEEF; es = 4'hF; end
        1:       begin ea = 40'h20; ed = 32'h1234_5678; es = 4'h3; end
        default: begin ea = '0;     ed = '0;            es = '0;   end
      endcase
      compare($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].rv, tbl[i].err,
              tbl[i].who != 3, ea, ed, es);
    end

    m_known = 1'b0; m_phase = 0; m_last = N - 1; m_gi = 0; m_used = 0; m_err = 1'b0;
    m_addr = '0; m_data = '0; m_strb = '0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      rst = (c == 0) || ($urandom_range(63) == 0);
      req_valid = 2'($urandom_range(3));
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
        req_data[i*DW +: DW] = $urandom();
        req_strb[i*SW +: SW] = SW'($urandom());
      end
      reg_wr_wait = ($urandom_range(2) == 0);
      reg_wr_ack  = ($urandom_range(3) == 0);

      m_pick = rr_pick(req_valid, m_last);
      e_rdy = '0; e_en = 1'b0; e_rv = '0; e_err = 1'b0;
      if (!rst) begin
        if (m_phase == 0 && m_pick >= 0) e_rdy = 2'(1 << m_pick);
        if (m_phase == 1) e_en = 1'b1;
        if (m_phase == 2) begin e_rv = 2'(1 << m_gi); e_err = m_err; end
      end
      @(negedge clk);
      compare($sformatf("rand%0d", c), e_rdy, e_en, e_rv, e_err, m_known,
              m_addr, m_data, m_strb);

      if (rst) begin
        m_phase = 0; m_last = N - 1; m_used = 0; m_known = 1'b1;
        m_addr = '0; m_data = '0; m_strb = '0;
      end else if (m_phase == 0) begin
        if (m_pick >= 0) begin
          m_gi = m_pick; m_last = m_pick; m_used = 0; m_phase = 1;
          m_addr = req_addr[m_pick*AW +: AW];
          m_data = req_data[m_pick*DW +: DW];
          m_strb = req_strb[m_pick*SW +: SW];
        end
      end else if (m_phase == 1) begin
        if (reg_wr_ack) begin
          m_err = 1'b0; m_phase = 2;
        end else if (!reg_wr_wait) begin
          m_used++;
          if (m_used >= TO) begin m_err = 1'b1; m_phase = 2; end
        end
      end else begin
        m_phase = 0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
